delay_out_fifo: RTL and testbench

//  Output buffer placed directly downstream of the fixed-latency delay line.

---
 rtl/delay_pkg.sv | 16 +
 rtl/delay_out_fifo_mem.sv | 31 +++
 rtl/delay_out_fifo.sv | 119 +++++++++++
 tb/tb_delay_out_fifo.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/delay_pkg.sv
// Shared types and helpers for the delay-line output FIFO.
package delay_pkg;

  localparam int DEFAULT_DEPTH = 4;

  typedef enum logic {
    COUNTING = 1'b0,
    WARM     = 1'b1
  } warm_state_e;

  // Pointer width for a power-of-two depth; never returns 0 so a 1-bit index always exists.
  function automatic int clog2_depth(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/delay_out_fifo_mem.sv
// DEPTH x N register array with one synchronous write port and one asynchronous read port.
module fifo_mem_dp
  import delay_pkg::*;
#(
  parameter int N     = 8,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          we_i,
  input  logic [clog2_depth(DEPTH)-1:0] waddr_i,
  input  logic [N-1:0]                  wdata_i,
  input  logic [clog2_depth(DEPTH)-1:0] raddr_i,
  output logic [N-1:0]                  rdata_o
);

  logic [N-1:0] mem_q [DEPTH];

  // NOTE: the array is reset explicitly so odata reads 0 straight after reset;
  // that costs a reset net per flop, acceptable at this tiny depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/delay_out_fifo.sv
// Output FIFO behind the delay line: drops SKIP warm-up samples, then buffers samples
// behind a valid/ready interface so the consumer can back-pressure a stall-free line.
module delay_out_fifo
  import delay_pkg::*;
#(
  parameter int N     = 8,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int SKIP  = 0
) (
  input  logic                         master_clk,
  input  logic                         master_rst_n,
  input  logic                         master_ce,
  input  logic                         clr,
  input  logic [N-1:0]                 idata,
  input  logic                         ivalid,
  output logic [N-1:0]                 odata,
  output logic                         ovalid,
  input  logic                         oready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         overflow,
  output logic                         warm
);

  typedef logic [N-1:0] sample_t;

  localparam int PW = clog2_depth(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = clog2_depth(SKIP + 1);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] skip_cnt_q, skip_cnt_d;
  logic          overflow_q, overflow_d;
  warm_state_e   warm_state_q, warm_state_d;

  logic    in_q, wr, rd, drop, mem_we;
  sample_t rdata;

  assign warm  = (warm_state_q == WARM);
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign in_q  = master_ce & ivalid;
  assign rd    = ~empty & oready;
  assign wr    = in_q & warm & (~full | rd);
  assign drop  = in_q & warm & full & ~rd;
  // A flush suppresses the same-cycle write so stale data cannot land behind the reset pointers.
  assign mem_we = wr & ~clr;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    skip_cnt_d   = skip_cnt_q;
    overflow_d   = overflow_q | drop;
    warm_state_d = warm_state_q;

    if (warm_state_q == COUNTING && in_q) begin
      if (skip_cnt_q == SW'(SKIP - 1)) warm_state_d = WARM;
      else                             skip_cnt_d   = skip_cnt_q + 1'b1;
    end

    if (clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (wr) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr, rd})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge master_clk or negedge master_rst_n) begin
    if (!master_rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      skip_cnt_q   <= '0;
      overflow_q   <= 1'b0;
      warm_state_q <= (SKIP == 0) ? WARM : COUNTING;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      skip_cnt_q   <= skip_cnt_d;
      overflow_q   <= overflow_d;
      warm_state_q <= warm_state_d;
    end
  end

  fifo_mem_dp #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (master_clk),
    .rst_n   (master_rst_n),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (idata),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  assign odata    = rdata;
  assign ovalid   = ~empty;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_delay_out_fifo.sv
// Directed bench for delay_out_fifo: SKIP=2 instance for the main scenarios, SKIP=0 instance for reset.
module tb_delay_out_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // SKIP=2 instance
  logic       rst_n, ce, clr, ivalid, oready;
  logic [7:0] idata, odata;
  logic       ovalid, full, empty, overflow, warm;
  logic [2:0] count;

  // SKIP=0 instance
  logic       rst0_n, ce0, clr0, ivalid0, oready0;
  logic [7:0] idata0, odata0;
  logic       ovalid0, full0, empty0, overflow0, warm0;
  logic [2:0] count0;

  delay_out_fifo #(.N(8), .DEPTH(4), .SKIP(2)) dut (
    .master_clk(clk), .master_rst_n(rst_n), .master_ce(ce), .clr(clr),
    .idata(idata), .ivalid(ivalid), .odata(odata), .ovalid(ovalid), .oready(oready),
    .count(count), .full(full), .empty(empty), .overflow(overflow), .warm(warm)
  );

  delay_out_fifo #(.N(8), .DEPTH(4), .SKIP(0)) dut0 (
    .master_clk(clk), .master_rst_n(rst0_n), .master_ce(ce0), .clr(clr0),
    .idata(idata0), .ivalid(ivalid0), .odata(odata0), .ovalid(ovalid0), .oready(oready0),
    .count(count0), .full(full0), .empty(empty0), .overflow(overflow0), .warm(warm0)
  );

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ce = 1'b0; clr = 1'b0; ivalid = 1'b0; oready = 1'b0; idata = 8'h00;
    rst0_n = 1'b0; ce0 = 1'b0; clr0 = 1'b0; ivalid0 = 1'b0; oready0 = 1'b0; idata0 = 8'h00;
    #12;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL reset_ovalid got=%b exp=0", ovalid); end
    checks++; if (odata !== 8'h00) begin errors++; $display("FAIL reset_odata got=%h exp=00", odata); end
    checks++; if (warm !== 1'b0) begin errors++; $display("FAIL reset_warm got=%b exp=0", warm); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (warm0 !== 1'b1) begin errors++; $display("FAIL reset_warm_skip0 got=%b exp=1", warm0); end
    rst_n = 1'b1; rst0_n = 1'b1;
    step();
  endtask

  task automatic test_warmup();
    oready = 1'b0; ce = 1'b1; ivalid = 1'b1;
    idata = 8'h00; step();
    checks++; if (warm !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL warm_s1 warm=%b count=%0d exp warm=0 count=0", warm, count); end
    idata = 8'h00; step();
    checks++; if (warm !== 1'b1 || count !== 3'd0) begin errors++; $display("FAIL warm_s2 warm=%b count=%0d exp warm=1 count=0", warm, count); end
    idata = 8'h11; step();
    checks++; if (count !== 3'd1 || odata !== 8'h11) begin errors++; $display("FAIL warm_s3 count=%0d odata=%h exp count=1 odata=11", count, odata); end
    idata = 8'h22; step();
    checks++; if (count !== 3'd2 || odata !== 8'h11) begin errors++; $display("FAIL warm_s4 count=%0d odata=%h exp count=2 odata=11", count, odata); end
    ivalid = 1'b0; oready = 1'b1; step();
    checks++; if (count !== 3'd1 || odata !== 8'h22) begin errors++; $display("FAIL warm_drain1 count=%0d odata=%h exp count=1 odata=22", count, odata); end
    step();
    checks++; if (empty !== 1'b1 || ovalid !== 1'b0) begin errors++; $display("FAIL warm_drain2 empty=%b ovalid=%b exp 1/0", empty, ovalid); end
    oready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [7:0] exp_q [4];
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    ivalid = 1'b1;
    for (int i = 1; i <= 4; i++) begin idata = 8'(i); step(); end
    checks++; if (count !== 3'd4 || full !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL ovf_fill count=%0d full=%b ovf=%b exp 4/1/0", count, full, overflow); end
    idata = 8'h05; step();
    checks++; if (count !== 3'd4 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_drop count=%0d ovf=%b exp 4/1", count, overflow); end
    ivalid = 1'b0; oready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (odata !== exp_q[i]) begin errors++; $display("FAIL ovf_drain%0d got=%h exp=%h", i, odata, exp_q[i]); end
      step();
    end
    checks++; if (empty !== 1'b1 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_empty empty=%b ovf=%b exp 1/1", empty, overflow); end
    oready = 1'b0;
  endtask

  task automatic test_full_rw();
    logic [7:0] exp_q [4];
    exp_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    ivalid = 1'b1;
    for (int i = 0; i < 4; i++) begin idata = 8'hA0 + 8'(i); step(); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL frw_full got=%b exp=1", full); end
    idata = 8'hA4; oready = 1'b1; step();
    checks++; if (count !== 3'd4 || odata !== 8'hA1 || overflow !== 1'b1) begin errors++; $display("FAIL frw_rw count=%0d odata=%h ovf=%b exp 4/a1/1", count, odata, overflow); end
    ivalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (odata !== exp_q[i]) begin errors++; $display("FAIL frw_drain%0d got=%h exp=%h", i, odata, exp_q[i]); end
      step();
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL frw_empty got=%b exp=1", empty); end
  endtask

  task automatic test_ce_toggle();
    oready = 1'b1; ivalid = 1'b1;
    ce = 1'b1; idata = 8'h31; step();
    checks++; if (ovalid !== 1'b1 || odata !== 8'h31 || count !== 3'd1) begin errors++; $display("FAIL ce_w1 ovalid=%b odata=%h count=%0d exp 1/31/1", ovalid, odata, count); end
    ce = 1'b0; idata = 8'h32; step();
    checks++; if (count !== 3'd0 || ovalid !== 1'b0) begin errors++; $display("FAIL ce_s1 count=%0d ovalid=%b exp 0/0", count, ovalid); end
    ce = 1'b1; idata = 8'h33; step();
    checks++; if (ovalid !== 1'b1 || odata !== 8'h33 || count !== 3'd1) begin errors++; $display("FAIL ce_w2 ovalid=%b odata=%h count=%0d exp 1/33/1", ovalid, odata, count); end
    ce = 1'b0; idata = 8'h34; step();
    checks++; if (count !== 3'd0 || ovalid !== 1'b0) begin errors++; $display("FAIL ce_s2 count=%0d ovalid=%b exp 0/0", count, ovalid); end
    ce = 1'b1; ivalid = 1'b0; oready = 1'b0;
  endtask

  task automatic test_clr();
    ivalid = 1'b1;
    for (int i = 1; i <= 3; i++) begin idata = 8'hC0 + 8'(i); step(); end
    checks++; if (count !== 3'd3 || overflow !== 1'b1) begin errors++; $display("FAIL clr_pre count=%0d ovf=%b exp 3/1", count, overflow); end
    clr = 1'b1; idata = 8'hC4; oready = 1'b1; step();
    checks++; if (count !== 3'd0 || empty !== 1'b1 || overflow !== 1'b0 || warm !== 1'b1) begin errors++; $display("FAIL clr_post count=%0d empty=%b ovf=%b warm=%b exp 0/1/0/1", count, empty, overflow, warm); end
    clr = 1'b0; oready = 1'b0; idata = 8'hD1; step();
    checks++; if (count !== 3'd1 || odata !== 8'hD1) begin errors++; $display("FAIL clr_after count=%0d odata=%h exp 1/d1", count, odata); end
    ivalid = 1'b0;
  endtask

  task automatic test_reset_mid();
    ce0 = 1'b1; ivalid0 = 1'b1; oready0 = 1'b0;
    idata0 = 8'h51; step();
    checks++; if (count0 !== 3'd1 || odata0 !== 8'h51) begin errors++; $display("FAIL rst0_w1 count=%0d odata=%h exp 1/51", count0, odata0); end
    idata0 = 8'h52; step();
    #2 rst0_n = 1'b0;
    #1;
    checks++; if (count0 !== 3'd0 || empty0 !== 1'b1 || ovalid0 !== 1'b0 || odata0 !== 8'h00 || full0 !== 1'b0 || overflow0 !== 1'b0 || warm0 !== 1'b1)
      begin errors++; $display("FAIL rst0_async count=%0d empty=%b ovalid=%b odata=%h full=%b ovf=%b warm=%b exp 0/1/0/00/0/0/1", count0, empty0, ovalid0, odata0, full0, overflow0, warm0); end
    #2 rst0_n = 1'b1;
    idata0 = 8'h53; step();
    checks++; if (count0 !== 3'd1 || odata0 !== 8'h53 || ovalid0 !== 1'b1) begin errors++; $display("FAIL rst0_next count=%0d odata=%h ovalid=%b exp 1/53/1", count0, odata0, ovalid0); end
    ivalid0 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_overflow();
    test_full_rw();
    test_ce_toggle();
    test_clr();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
